// File: rtl/pcie_pkt_gen_pkg.sv
// pcie_pkt_gen_pkg: shared TLP types, Fmt/Type codes, framing symbols and FSM states for pcie_pkt_gen.
// The LCRC state exists only when PCIE_PKT_GEN_LCRC_EN is defined.
package pcie_pkt_gen_pkg;
    typedef enum logic [3:0] {
        MRD, MWR, IORD, IOWR, CFGRD0, CFGWR0, CFGRD1, CFGWR1, CPL, CPLD
    } pkt_type_e;
    localparam logic [7:0] FMT_TYPE [0:9] = '{
        8'h00, 8'h40, 8'h02, 8'h42, 8'h04, 8'h44, 8'h05, 8'h45, 8'h0A, 8'h4A
    };
    localparam logic [3:0] NUM_TYPES = 4'd10;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] IDLE_SYM = 8'h00;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_SEED = 32'hFFFFFFFF;
    typedef enum logic [2:0] {
        IDLE, STP, SEQ, HDR, DATA,
`ifdef PCIE_PKT_GEN_LCRC_EN
        LCRC,
`endif
        END
    } tx_state_e;
    function automatic logic has_data(pkt_type_e t);
        return t inside {MWR, IOWR, CFGWR0, CFGWR1, CPLD};
    endfunction
endpackage

// File: rtl/pcie_pkt_gen_if.sv
// pcie_pkt_gen_if: request handshake bundle (req_valid/req_ready, req_type, req_hdr, req_data).
// master drives the request, slave (the generator) returns req_ready.
interface pcie_pkt_gen_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_type;
    logic [87:0] req_hdr;
    logic [31:0] req_data;
    modport master (output req_valid, req_type, req_hdr, req_data, input req_ready);
    modport slave (input req_valid, req_type, req_hdr, req_data, output req_ready);
endinterface

// File: rtl/pcie_lcrc32.sv
// pcie_lcrc32: byte-wide CRC-32 (poly 04C11DB7, seed FFFFFFFF, bytes fed LSB first).
// Ports: clk, reset (sync, active-high), init (load seed), en (absorb byte_in), crc_out (raw register).
module pcie_lcrc32
    import pcie_pkt_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);
    logic [31:0] nxt;

    always_comb begin
        nxt = crc_out;
        for (int i = 0; i < 8; i++)
            nxt = {nxt[30:0], 1'b0} ^ ({32{byte_in[i] ^ nxt[31]}} & CRC_POLY);
    end

    always_ff @(posedge clk)
        if (reset || init) crc_out <= CRC_SEED;
        else if (en) crc_out <= nxt;
endmodule

// File: rtl/pcie_pkt_gen.sv
// pcie_pkt_gen: byte-serial PCIe TLP transmitter framing STP/SEQ/HDR/[DATA]/[LCRC]/END symbols.
// Ports: clk, reset (sync, active-high), req (pcie_pkt_gen_if.slave request handshake),
//        data_out/dataK (symbol stream), busy, tx_done (END pulse), err_type (bad type pulse),
//        pkt_count (packets sent, wrapping).
// Build option: PCIE_PKT_GEN_LCRC_EN adds 4 LCRC bytes before END.
module pcie_pkt_gen
    import pcie_pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int PKT_CNT_WIDTH = 4,
    parameter int SEQ_WIDTH     = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    pcie_pkt_gen_if.slave            req,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     dataK,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     err_type,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count
);
`ifdef PCIE_PKT_GEN_LCRC_EN
    localparam tx_state_e BODY_END = LCRC;
`else
    localparam tx_state_e BODY_END = END;
`endif
    tx_state_e state, state_n;
    logic [4:0] idx, idx_n;
    pkt_type_e typ_q;
    logic [87:0] hdr_q;
    logic [31:0] data_q;
    logic [SEQ_WIDTH-1:0] seq;
    logic [15:0] seq16;
    logic [7:0] sym;
    logic accept, err_q;

    assign req.req_ready = state == IDLE;
    assign accept = req.req_valid && req.req_ready;
    assign seq16 = 16'(seq);
    assign data_out = DATA_WIDTH'(sym);
    assign dataK = state == STP || state == END;
    assign busy = state != IDLE;
    assign tx_done = state == END;
    assign err_type = err_q;

`ifdef PCIE_PKT_GEN_LCRC_EN
    logic [31:0] crc_out, crc_inv;
    pcie_lcrc32 u_lcrc (
        .clk     (clk),
        .reset   (reset),
        .init    (state == STP),
        .en      (state inside {SEQ, HDR, DATA}),
        .byte_in (sym),
        .crc_out (crc_out)
    );
    assign crc_inv = ~crc_out;
`endif

    // idx restarts at 0 on every state change and counts bytes within a state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept && req.req_type < NUM_TYPES ? STP : IDLE;
            STP:     state_n = SEQ;
            SEQ:     state_n = idx == 5'd1 ? HDR : SEQ;
            HDR:     state_n = idx == 5'd11 ? (has_data(typ_q) ? DATA : BODY_END) : HDR;
            DATA:    state_n = idx == 5'd3 ? BODY_END : DATA;
`ifdef PCIE_PKT_GEN_LCRC_EN
            LCRC:    state_n = idx == 5'd3 ? END : LCRC;
`endif
            END:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        idx_n = state_n == state ? idx + 5'd1 : 5'd0;
    end

    always_comb begin
        sym = IDLE_SYM;
        case (state)
            STP:     sym = K_STP;
            SEQ:     sym = idx[0] ? seq16[7:0] : seq16[15:8];
            HDR:     sym = idx == 5'd0 ? FMT_TYPE[typ_q] : hdr_q[87:80];
            DATA:    sym = data_q[31:24];
`ifdef PCIE_PKT_GEN_LCRC_EN
            LCRC:    sym = crc_inv[{idx[1:0], 3'b000} +: 8];
`endif
            END:     sym = K_END;
            default: sym = IDLE_SYM;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            seq <= '0;
            pkt_count <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            err_q <= accept && req.req_type >= NUM_TYPES;
            if (state == END) begin
                seq <= seq + 1'b1;
                pkt_count <= pkt_count + 1'b1;
            end
        end

    // header/data are shifted out MSB byte first once the Fmt/Type byte is gone
    always_ff @(posedge clk)
        if (accept) begin
            typ_q <= pkt_type_e'(req.req_type);
            hdr_q <= req.req_hdr;
            data_q <= req.req_data;
        end else begin
            if (state == HDR && idx != 5'd0) hdr_q <= hdr_q << 8;
            if (state == DATA) data_q <= data_q << 8;
        end
endmodule

// File: tb/tb_pcie_pkt_gen.sv
// tb_pcie_pkt_gen: table-driven self-checking bench for pcie_pkt_gen plus wrap and mid-packet reset sequences.
module tb_pcie_pkt_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pcie_pkt_gen_if rq();
    logic [7:0] data_out;
    logic dataK, busy, tx_done, err_type;
    logic [3:0] pkt_count;

    pcie_pkt_gen dut (
        .clk       (clk),
        .reset     (reset),
        .req       (rq),
        .data_out  (data_out),
        .dataK     (dataK),
        .busy      (busy),
        .tx_done   (tx_done),
        .err_type  (err_type),
        .pkt_count (pkt_count)
    );

`ifdef PCIE_PKT_GEN_LCRC_EN
    localparam int LCRC_N = 4;
`else
    localparam int LCRC_N = 0;
`endif

    typedef struct {
        logic [3:0]  t;
        logic [87:0] hdr;
        logic [31:0] d;
        int          len;
        logic [7:0]  b0;
        logic        err;
    } vec_t;
    vec_t vt[12];

    int checks = 0;
    int errors = 0;
    logic [11:0] seq_m;
    logic [3:0] pkt_m;
    logic [8:0] exp_f[32];
    logic [8:0] got_f[32];
    int exp_n, got_n;
    bit frame_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] t, input logic [87:0] hdr, input logic [31:0] d);
        int w = 0;
        while (!rq.req_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(rq.req_ready), 32'd1);
        rq.req_valid = 1'b1;
        rq.req_type = t;
        rq.req_hdr = hdr;
        rq.req_data = d;
        tick();
        rq.req_valid = 1'b0;
        rq.req_type = 4'h7;
        rq.req_hdr = {11{8'hA5}};
        rq.req_data = 32'h5A5A5A5A;
    endtask

    task automatic collect();
        got_n = 0;
        frame_bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            got_f[i] = {dataK, data_out};
            got_n = i + 1;
            if (tx_done !== (dataK && data_out == 8'hFD)) frame_bad = 1'b1;
            if (busy !== 1'b1 || rq.req_ready !== 1'b0) frame_bad = 1'b1;
            if (dataK && data_out == 8'hFD) break;
            tick();
        end
    endtask

`ifdef PCIE_PKT_GEN_LCRC_EN
    function automatic logic [31:0] crc_ref(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [7:0] rb;
        for (int j = 1; j < n; j++) begin
            for (int b = 0; b < 8; b++) rb[b] = exp_f[j][7-b];
            c = c ^ {rb, 24'h0};
            for (int b = 0; b < 8; b++) c = c[31] ? (c << 1) ^ 32'h04C11DB7 : c << 1;
        end
        return ~c;
    endfunction
`endif

    task automatic build_exp(input logic [7:0] b0, input logic [87:0] hdr, input logic [31:0] d, input bit has_d);
        int n;
        logic [31:0] c;
        exp_f[0] = {1'b1, 8'hFB};
        exp_f[1] = {1'b0, 4'h0, seq_m[11:8]};
        exp_f[2] = {1'b0, seq_m[7:0]};
        exp_f[3] = {1'b0, b0};
        for (int i = 0; i < 11; i++) exp_f[4+i] = {1'b0, hdr[87-8*i -: 8]};
        n = 15;
        if (has_d)
            for (int i = 0; i < 4; i++) begin
                exp_f[n] = {1'b0, d[31-8*i -: 8]};
                n++;
            end
        c = 32'h0;
`ifdef PCIE_PKT_GEN_LCRC_EN
        c = crc_ref(n);
        for (int i = 0; i < 4; i++) begin
            exp_f[n] = {1'b0, c[8*i +: 8]};
            n++;
        end
`endif
        exp_f[n] = {1'b1, 8'hFD};
        exp_n = n + 1;
    endtask

    task automatic compare_frame(input string nm);
        chk({nm, " len"}, 32'(got_n), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_n; i++)
            chk($sformatf("%s sym%0d", nm, i), 32'(got_f[i]), 32'(exp_f[i]));
        chk({nm, " txdone/busy"}, 32'(frame_bad), 32'd0);
    endtask

    task automatic after_frame(input string nm);
        seq_m++;
        pkt_m++;
        tick();
        chk({nm, " gap sym"}, 32'({dataK, data_out}), 32'd0);
        chk({nm, " gap ready"}, 32'(rq.req_ready), 32'd1);
        chk({nm, " pkt_count"}, 32'(pkt_count), 32'(pkt_m));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit abort;
        logic [7:0] s0, s1;
        vt[0]  = '{4'd0,  88'h0, 32'h0, 16, 8'h00, 1'b0};
        vt[1]  = '{4'd1,  88'h00112233445566778899AA, 32'hDEADBEEF, 20, 8'h40, 1'b0};
        vt[2]  = '{4'd12, 88'h0102030405060708090A0B, 32'h11111111, 0, 8'h00, 1'b1};
        vt[3]  = '{4'd2,  88'h0102030405060708090A0B, 32'h12345678, 16, 8'h02, 1'b0};
        vt[4]  = '{4'd3,  88'hFFEEDDCCBBAA9988776655, 32'hCAFEF00D, 20, 8'h42, 1'b0};
        vt[5]  = '{4'd4,  88'h1, 32'h0, 16, 8'h04, 1'b0};
        vt[6]  = '{4'd5,  {11{8'h5A}}, 32'h00000001, 20, 8'h44, 1'b0};
        vt[7]  = '{4'd6,  {11{8'hC3}}, 32'hFFFFFFFF, 16, 8'h05, 1'b0};
        vt[8]  = '{4'd15, {11{8'h77}}, 32'h0, 0, 8'h00, 1'b1};
        vt[9]  = '{4'd7,  88'h800000000000000000007F, 32'h80000000, 20, 8'h45, 1'b0};
        vt[10] = '{4'd8,  88'h123456789ABCDEF0112233, 32'h0, 16, 8'h0A, 1'b0};
        vt[11] = '{4'd9,  88'hA1B2C3D4E5F60718293A4B, 32'h01020304, 20, 8'h4A, 1'b0};
        rq.req_valid = 1'b0;
        rq.req_type = 4'h0;
        rq.req_hdr = 88'h0;
        rq.req_data = 32'h0;
        tick();
        chk("rst data_out", 32'(data_out), 32'h00);
        chk("rst dataK", 32'(dataK), 32'd0);
        chk("rst ready", 32'(rq.req_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst tx_done", 32'(tx_done), 32'd0);
        chk("rst err_type", 32'(err_type), 32'd0);
        chk("rst pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        seq_m = '0;
        pkt_m = '0;
        repeat (3) tick();
        chk("idle sym", 32'({dataK, data_out}), 32'd0);

        for (int v = 0; v < 12; v++) begin
            send(vt[v].t, vt[v].hdr, vt[v].d);
            if (vt[v].err) begin
                chk($sformatf("vec%0d err pulse", v), 32'(err_type), 32'd1);
                chk($sformatf("vec%0d err sym", v), 32'({dataK, data_out}), 32'd0);
                chk($sformatf("vec%0d err busy", v), 32'(busy), 32'd0);
                tick();
                chk($sformatf("vec%0d err clear", v), 32'(err_type), 32'd0);
                chk($sformatf("vec%0d err sym2", v), 32'({dataK, data_out}), 32'd0);
                chk($sformatf("vec%0d err count", v), 32'(pkt_count), 32'(pkt_m));
            end else begin
                chk($sformatf("vec%0d no err", v), 32'(err_type), 32'd0);
                collect();
                build_exp(vt[v].b0, vt[v].hdr, vt[v].d, vt[v].len == 20);
                chk($sformatf("vec%0d table len", v), 32'(got_n), 32'(vt[v].len + LCRC_N));
                compare_frame($sformatf("vec%0d", v));
                after_frame($sformatf("vec%0d", v));
            end
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        seq_m = '0;
        pkt_m = '0;
        rq.req_valid = 1'b1;
        rq.req_type = 4'd4;
        rq.req_hdr = 88'h0;
        rq.req_data = 32'h0;
        abort = 1'b0;
        for (int p = 1; p <= 4097 && !abort; p++) begin
            w = 0;
            while (!(dataK && data_out == 8'hFB) && w < 40) begin
                tick();
                w++;
            end
            if (w >= 40) begin
                chk("b2b stp wait", 32'({dataK, data_out}), 32'h1FB);
                abort = 1'b1;
            end else begin
                tick();
                s0 = data_out;
                tick();
                s1 = data_out;
                chk("b2b seq", 32'({s0, s1}), 32'({4'h0, seq_m}));
                if (p == 4096) chk("seq 4096", 32'({s0, s1}), 32'h0FFF);
                if (p == 4097) chk("seq 4097", 32'({s0, s1}), 32'h0000);
                w = 0;
                while (!tx_done && w < 40) begin
                    tick();
                    w++;
                end
                if (w >= 40) begin
                    chk("b2b end wait", 32'(tx_done), 32'd1);
                    abort = 1'b1;
                end else begin
                    seq_m++;
                    pkt_m++;
                    if (p == 4097) rq.req_valid = 1'b0;
                    tick();
                    chk("b2b count", 32'(pkt_count), 32'(pkt_m));
                    chk("b2b gap", 32'({dataK, data_out}), 32'd0);
                    if (p == 16) chk("pkt wrap", 32'(pkt_count), 32'h0);
                end
            end
        end

        send(4'd0, 88'h0102030405060708090A0B, 32'h0);
        repeat (8) tick();
        chk("mid hdr5", 32'({dataK, data_out}), 32'h005);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid rst sym", 32'({dataK, data_out}), 32'd0);
        chk("mid rst ready", 32'(rq.req_ready), 32'd1);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst tx_done", 32'(tx_done), 32'd0);
        chk("mid rst count", 32'(pkt_count), 32'd0);
        seq_m = '0;
        pkt_m = '0;
        send(4'd0, 88'h0102030405060708090A0B, 32'h0);
        collect();
        build_exp(8'h00, 88'h0102030405060708090A0B, 32'h0, 1'b0);
        compare_frame("post rst");
        after_frame("post rst");
        repeat (4) tick();
        chk("final idle", 32'({dataK, data_out}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
